// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    MUL = 1'b1
  } pipe_state_e;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned MUL_LAT_DEF = 3;

endpackage

// File: rtl/pipe_lu_detect.sv
// Combinational load-use comparator: a load in EXE whose rd is read by the instruction in ID.
module pipe_lu_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_rd_we,
  input  logic                  exe_is_load,
  output logic                  hazard
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1 == exe_rd);
    rs2_hit = id_rs2_used && (id_rs2 == exe_rd);
    // x0 is hardwired zero, so a load targeting it can never create a dependency
    hazard  = exe_is_load && exe_rd_we && (exe_rd != '0) && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/stall controller: multiply sequencing, memory waits, load-use and branch flushes.
// Optional perf counters enabled by defining PIPE_CTRL_PERF_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = MUL_LAT_DEF,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] exe_rd,
  input  logic                  exe_rd_we,
  input  logic                  exe_is_load,
  input  logic                  exe_is_mul,
  input  logic                  exe_br_taken,
  input  logic                  im_wait,
  input  logic                  dm_wait,
  output logic                  stall_IF,
  output logic                  stall_ID,
  output logic                  flush_ID,
  output logic                  flush_EXE,
  output logic                  mul_busy,
  output logic [CNT_W-1:0]      perf_stall_cnt,
  output logic [CNT_W-1:0]      perf_flush_cnt,
  output logic [CNT_W-1:0]      perf_lu_cnt
);

  localparam logic            MUL_MC   = (MUL_LAT > 1);
  localparam int unsigned     MC_W     = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
  localparam logic [MC_W-1:0] MUL_INIT = MC_W'((MUL_LAT >= 2) ? (MUL_LAT - 2) : 0);

  pipe_state_e     state;
  logic [MC_W-1:0] mul_cnt;

  logic lu_hazard;
  logic mul_stall;
  logic stall_c;
  logic br_c;
  logic lu_c;

  pipe_lu_detect u_lu_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .exe_rd      (exe_rd),
    .exe_rd_we   (exe_rd_we),
    .exe_is_load (exe_is_load),
    .hazard      (lu_hazard)
  );

  // Outputs are Mealy so the freeze applies in the same cycle the multiply reaches EXE
  always_comb begin
    mul_stall = ((state == RUN) && exe_is_mul && MUL_MC) ||
                ((state == MUL) && (mul_cnt != '0));
    stall_c   = im_wait || dm_wait || mul_stall;
    br_c      = !stall_c && exe_br_taken;
    lu_c      = !stall_c && !exe_br_taken && lu_hazard;

    stall_IF  = !rst && stall_c;
    flush_ID  = !rst && br_c;
    flush_EXE = !rst && (br_c || lu_c);
    stall_ID  = !rst && lu_c;
    mul_busy  = !rst && (state == MUL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      case (state)
        RUN: begin
          if (exe_is_mul && MUL_MC) begin
            state   <= MUL;
            mul_cnt <= MUL_INIT;
          end
        end
        MUL: begin
          // The countdown continues under memory waits; only the exit waits for them
          if (mul_cnt != '0) begin
            mul_cnt <= mul_cnt - MC_W'(1);
          end else if (!im_wait && !dm_wait) begin
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;
  logic [CNT_W-1:0] lu_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      if (stall_c) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (br_c)    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (lu_c)    lu_cnt_q    <= lu_cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    perf_stall_cnt = rst ? '0 : stall_cnt_q;
    perf_flush_cnt = rst ? '0 : flush_cnt_q;
    perf_lu_cnt    = rst ? '0 : lu_cnt_q;
  end
`else
  always_comb begin
    perf_stall_cnt = '0;
    perf_flush_cnt = '0;
    perf_lu_cnt    = '0;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl with MUL_LAT=3.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, exe_rd;
  logic       id_rs1_used, id_rs2_used, exe_rd_we, exe_is_load, exe_is_mul;
  logic       exe_br_taken, im_wait, dm_wait;
  logic       stall_IF, stall_ID, flush_ID, flush_EXE, mul_busy;
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_lu_cnt;

  int unsigned checks = 0;
  int unsigned passed = 0;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] EXP_PERF_STALL = 32'd4;
`else
  localparam logic [31:0] EXP_PERF_STALL = 32'd0;
`endif

  pipe_hazard_ctrl #(.MUL_LAT(3), .CNT_W(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_rs1_used    (id_rs1_used),
    .id_rs2_used    (id_rs2_used),
    .exe_rd         (exe_rd),
    .exe_rd_we      (exe_rd_we),
    .exe_is_load    (exe_is_load),
    .exe_is_mul     (exe_is_mul),
    .exe_br_taken   (exe_br_taken),
    .im_wait        (im_wait),
    .dm_wait        (dm_wait),
    .stall_IF       (stall_IF),
    .stall_ID       (stall_ID),
    .flush_ID       (flush_ID),
    .flush_EXE      (flush_EXE),
    .mul_busy       (mul_busy),
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt),
    .perf_lu_cnt    (perf_lu_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; exe_rd = 5'd0;
    id_rs1_used = 1'b0; id_rs2_used = 1'b0; exe_rd_we = 1'b0;
    exe_is_load = 1'b0; exe_is_mul = 1'b0; exe_br_taken = 1'b0;
    im_wait = 1'b0; dm_wait = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
    exe_is_mul = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (mul_busy !== 1'b1) $display("FAIL reset_premul_busy got=%b exp=1", mul_busy);
    else passed++;
    next_cycle();
    rst = 1'b1; im_wait = 1'b1; exe_br_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({stall_IF, stall_ID, flush_ID, flush_EXE, mul_busy} !== 5'b0)
        $display("FAIL reset_hold_c%0d got=%b exp=00000", i,
                 {stall_IF, stall_ID, flush_ID, flush_EXE, mul_busy});
      else passed++;
      next_cycle();
    end
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({stall_IF, stall_ID, flush_ID, flush_EXE, mul_busy} !== 5'b0)
      $display("FAIL reset_idle got=%b exp=00000", {stall_IF, stall_ID, flush_ID, flush_EXE, mul_busy});
    else passed++;
    checks++;
    if ({perf_stall_cnt, perf_flush_cnt, perf_lu_cnt} !== 96'd0)
      $display("FAIL reset_perf got=%0d/%0d/%0d exp=0/0/0", perf_stall_cnt, perf_flush_cnt, perf_lu_cnt);
    else passed++;
    next_cycle();
  endtask

  task automatic test_mul();
    logic [3:0] exp_stall;
    logic [3:0] exp_busy;
    exp_stall = 4'b0011;
    exp_busy  = 4'b0110;
    idle();
    for (int c = 0; c < 4; c++) begin
      exe_is_mul = (c < 3);
      @(negedge clk);
      checks++;
      if (stall_IF !== exp_stall[c]) $display("FAIL mul_stall_c%0d got=%b exp=%b", c, stall_IF, exp_stall[c]);
      else passed++;
      checks++;
      if (mul_busy !== exp_busy[c]) $display("FAIL mul_busy_c%0d got=%b exp=%b", c, mul_busy, exp_busy[c]);
      else passed++;
      next_cycle();
    end
    idle();
  endtask

  task automatic test_load_use();
    // {load, we, rd, rs1, rs1_used, rs2, rs2_used} -> expected {stall_IF, stall_ID, flush_ID, flush_EXE}
    logic [19:0] vec [5];
    logic [3:0]  exp  [5];
    vec[0] = {1'b1, 1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0}; exp[0] = 4'b0101;
    vec[1] = {1'b1, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1}; exp[1] = 4'b0000;
    vec[2] = {1'b1, 1'b1, 5'd9, 5'd1, 1'b1, 5'd9, 1'b1}; exp[2] = 4'b0101;
    vec[3] = {1'b1, 1'b1, 5'd9, 5'd9, 1'b0, 5'd9, 1'b0}; exp[3] = 4'b0000;
    vec[4] = {1'b1, 1'b0, 5'd7, 5'd7, 1'b1, 5'd0, 1'b0}; exp[4] = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      idle();
      {exe_is_load, exe_rd_we, exe_rd, id_rs1, id_rs1_used, id_rs2, id_rs2_used} = vec[i];
      @(negedge clk);
      checks++;
      if ({stall_IF, stall_ID, flush_ID, flush_EXE} !== exp[i])
        $display("FAIL lu_vec%0d got=%b exp=%b", i, {stall_IF, stall_ID, flush_ID, flush_EXE}, exp[i]);
      else passed++;
      next_cycle();
    end
    idle();
    exe_is_load = 1'b1; exe_rd_we = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    im_wait = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_IF, stall_ID, flush_ID, flush_EXE} !== 4'b1000)
      $display("FAIL lu_under_imwait got=%b exp=1000", {stall_IF, stall_ID, flush_ID, flush_EXE});
    else passed++;
    next_cycle();
    idle();
  endtask

  task automatic test_branch_priority();
    idle();
    exe_is_load = 1'b1; exe_rd_we = 1'b1; exe_rd = 5'd5; id_rs1 = 5'd5; id_rs1_used = 1'b1;
    exe_br_taken = 1'b1;
    @(negedge clk);
    checks++;
    if ({stall_IF, stall_ID, flush_ID, flush_EXE} !== 4'b0011)
      $display("FAIL br_over_lu got=%b exp=0011", {stall_IF, stall_ID, flush_ID, flush_EXE});
    else passed++;
    next_cycle();
    idle();
  endtask

  task automatic test_mem_wait_branch();
    idle();
    exe_br_taken = 1'b1;
    for (int c = 0; c < 5; c++) begin
      dm_wait = (c < 4);
      @(negedge clk);
      checks++;
      if (c < 4) begin
        if ({stall_IF, stall_ID, flush_ID, flush_EXE} !== 4'b1000)
          $display("FAIL dmwait_br_c%0d got=%b exp=1000", c, {stall_IF, stall_ID, flush_ID, flush_EXE});
        else passed++;
      end else begin
        if ({stall_IF, stall_ID, flush_ID, flush_EXE} !== 4'b0011)
          $display("FAIL dmwait_br_release got=%b exp=0011", {stall_IF, stall_ID, flush_ID, flush_EXE});
        else passed++;
      end
      next_cycle();
    end
    idle();
  endtask

  task automatic test_mul_mem_wait();
    logic [5:0] exp_stall;
    logic [5:0] exp_busy;
    exp_stall = 6'b001111;
    exp_busy  = 6'b011110;
    idle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      exe_is_mul = (c < 5);
      dm_wait    = (c == 2) || (c == 3);
      @(negedge clk);
      checks++;
      if (stall_IF !== exp_stall[c]) $display("FAIL mulwait_stall_c%0d got=%b exp=%b", c, stall_IF, exp_stall[c]);
      else passed++;
      checks++;
      if (mul_busy !== exp_busy[c]) $display("FAIL mulwait_busy_c%0d got=%b exp=%b", c, mul_busy, exp_busy[c]);
      else passed++;
      next_cycle();
    end
    idle();
    @(negedge clk);
    checks++;
    if (perf_stall_cnt !== EXP_PERF_STALL)
      $display("FAIL perf_stall_cnt got=%0d exp=%0d", perf_stall_cnt, EXP_PERF_STALL);
    else passed++;
    checks++;
    if ({perf_flush_cnt, perf_lu_cnt} !== 64'd0)
      $display("FAIL perf_flush_lu got=%0d/%0d exp=0/0", perf_flush_cnt, perf_lu_cnt);
    else passed++;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_load_use();
    test_branch_priority();
    test_mem_wait_branch();
    test_mul_mem_wait();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
